sram_word_bridge: RTL and testbench
===================================

SRAM_WORD_BRIDGE -- requirements
Module: sram_word_bridge

Interface
REQ-001 Parameter RD_LAT, default 1, SRAM read latency in cycles from a read-issue cycle to sram_dout valid; legal values 1 or 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  word request present.
REQ-005 req_ready  output  1  bridge accepts request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  11  byte address; bits [1:0] ignored, word = req_addr[10:2].
REQ-008 req_wstrb  input  4  byte-lane write enables, lane i = req_wdata[8i+7:8i].
REQ-009 req_wdata  input  32  write data, little-endian lanes.
REQ-010 resp_valid  output  1  one-cycle completion pulse for reads and writes.
REQ-011 resp_rdata  output  32  read data; lane i from SRAM byte {word, i}.
REQ-012 sram_ce  output  1  SRAM access enable.
REQ-013 sram_wre  output  1  SRAM write enable, meaningful only with sram_ce.
REQ-014 sram_ad  output  11  SRAM byte address.
REQ-015 sram_din  output  8  SRAM write byte.
REQ-016 sram_dout  input  8  SRAM read byte, valid RD_LAT cycles after issue.

Function
REQ-017 States: IDLE, WRITE, READ, DRAIN, RESP; req_ready = 1 only in IDLE and not in reset.
REQ-018 Accept = req_valid & req_ready in cycle 0; address, we, wstrb, wdata latched at end of cycle 0; request inputs ignored while not IDLE.
REQ-019 Write accept, wstrb != 0 -> WRITE: one SRAM write per enabled lane in ascending lane order, consecutive cycles 1..n (n = popcount(wstrb)); disabled lanes issue no SRAM cycle.
REQ-020 Each write cycle: sram_ce=1, sram_wre=1, sram_ad={word,lane[1:0]}, sram_din=latched lane byte.
REQ-021 After last write -> RESP; resp_valid high in cycle n+1; then IDLE (req_ready high in cycle n+2).
REQ-022 Write with wstrb = 0: no SRAM cycle; resp_valid in cycle 1.
REQ-023 Read accept -> READ: sram_ce=1, sram_wre=0, sram_ad={word,k} in cycle k+1 for k=0..3, back-to-back.
REQ-024 Byte k captured into resp_rdata[8k+7:8k] at end of cycle k+1+RD_LAT; DRAIN covers cycles 5..4+RD_LAT with sram_ce=0.
REQ-025 resp_valid high in cycle 5+RD_LAT (6 for RD_LAT=1); req_ready high next cycle.
REQ-026 resp_rdata holds its value from the last completed read until the next read's bytes are captured; writes leave it unchanged.
REQ-027 sram_ce=0, sram_wre=0 in IDLE, DRAIN, RESP; sram_ad and sram_din hold last driven value when sram_ce=0.
REQ-028 resp_valid is never high for more than one consecutive cycle; no response backpressure.
REQ-029 At most one outstanding request; exactly one resp_valid per accepted request unless reset intervenes.

Reset
REQ-030 reset sampled high: state=IDLE; req_ready=0 that cycle, 1 next cycle if reset low; resp_valid=0, sram_ce=0, sram_wre=0, sram_ad=0, sram_din=0, resp_rdata=0 after the edge.
REQ-031 Reset mid-operation aborts the transaction: no further SRAM cycles, no resp_valid for it; already-written bytes stay written; in-flight read bytes discarded.
REQ-032 Request presented in a reset cycle is not accepted.

Verification
REQ-033 Write 0x11223344 to addr 0x010, wstrb=1111 -> writes ad 0x010..0x013 with 44,33,22,11 in cycles 1-4, resp_valid cycle 5; read of 0x010 returns 0x11223344, resp_valid cycle 6 (RD_LAT=1).
REQ-034 Write 0xAABBCCDD to 0x7FC, wstrb=0101 -> only ad 0x7FC=DD (cycle 1), ad 0x7FE=BB (cycle 2), resp_valid cycle 3; read 0x7FC with prior zeros -> 0x00BB00DD.
REQ-035 Write wstrb=0000 -> no sram_ce activity, resp_valid cycle 1; req_addr=0x013 read equals read of 0x010.
REQ-036 RD_LAT=2: read issues cycles 1-4, resp_valid cycle 7, data correct; req_valid held high during busy -> exactly one acceptance per IDLE.
REQ-037 Reset asserted in cycle 2 of a 4-lane write -> only lane 0 written, no resp_valid, all outputs at reset values, next request accepted normally.

Source files
------------

// File: rtl/sram_word_bridge.sv
// Bridges 32-bit word requests onto a byte-wide synchronous SRAM: writes issue one
// SRAM cycle per enabled lane, reads fetch all four bytes back-to-back.
module sram_word_bridge #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [10:0] req_addr,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        sram_ce,
    output logic        sram_wre,
    output logic [10:0] sram_ad,
    output logic [7:0]  sram_din,
    input  logic [7:0]  sram_dout,
    output logic [2:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only while idle, and resp_valid is a single-cycle pulse that
    // cannot be stalled.
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;

    state_t      state, state_nx;
    logic [8:0]  word_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic [10:0] ad_q;
    logic [7:0]  din_q;
    logic [31:0] rdata_q;
    logic [RD_LAT-1:0] pipe_v;
    logic [1:0]  pipe_lane [RD_LAT];
    logic        accept;
    logic        last_cap;
    logic        unused_addr_bits;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [3:0] clr_low(input logic [3:0] m);
        return m & (m - 4'd1);
    endfunction

    assign accept           = req_valid & req_ready;
    assign last_cap         = pipe_v[RD_LAT-1] && (pipe_lane[RD_LAT-1] == 2'd3);
    assign unused_addr_bits = ^req_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) begin
                       if (req_we) state_nx = (req_wstrb != 4'd0) ? WRITE : RESP;
                       else        state_nx = READ;
                   end
            // mask_q holds the lanes still to be written after the current one
            WRITE: if (mask_q == 4'd0) state_nx = RESP;
            READ:  if (ad_q[1:0] == 2'd3) state_nx = DRAIN;
            DRAIN: if (last_cap) state_nx = RESP;
            RESP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) && !reset;
        resp_valid = (state == RESP) && !reset;
        sram_ce    = ((state == WRITE) || (state == READ)) && !reset;
        sram_wre   = (state == WRITE) && !reset;
        sram_ad    = ad_q;
        sram_din   = din_q;
        resp_rdata = rdata_q;
        dbg_state  = state;
    end

    // SRAM address/data are registered one edge ahead so they hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            ad_q    <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            pipe_v  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    word_q  <= req_addr[10:2];
                    wdata_q <= req_wdata;
                    if (req_we) begin
                        if (req_wstrb != 4'd0) begin
                            ad_q   <= {req_addr[10:2], low_lane(req_wstrb)};
                            din_q  <= req_wdata[{low_lane(req_wstrb), 3'b000} +: 8];
                            mask_q <= clr_low(req_wstrb);
                        end
                    end else begin
                        ad_q <= {req_addr[10:2], 2'd0};
                    end
                end
                WRITE: if (mask_q != 4'd0) begin
                    ad_q   <= {word_q, low_lane(mask_q)};
                    din_q  <= wdata_q[{low_lane(mask_q), 3'b000} +: 8];
                    mask_q <= clr_low(mask_q);
                end
                READ: if (ad_q[1:0] != 2'd3) ad_q <= {word_q, ad_q[1:0] + 2'd1};
                default: ;
            endcase

            // Track each read issue for RD_LAT cycles so the returning byte lands in its lane.
            pipe_v[0]    <= sram_ce & ~sram_wre;
            pipe_lane[0] <= ad_q[1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_lane[i] <= pipe_lane[i-1];
            end
            if (pipe_v[RD_LAT-1]) rdata_q[{pipe_lane[RD_LAT-1], 3'b000} +: 8] <= sram_dout;
        end
    end

endmodule

// File: tb/tb_sram_word_bridge.sv
// Bench for sram_word_bridge: RD_LAT=1 and RD_LAT=2 instances run in lockstep against
// byte-array SRAM models and a word-level reference memory.
module tb_sram_word_bridge;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [10:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;

    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        sram_ce    [2];
    logic        sram_wre   [2];
    logic [10:0] sram_ad    [2];
    logic [7:0]  sram_din   [2];
    logic [7:0]  sram_dout  [2];
    logic [2:0]  dbg_state  [2];

    // SRAM models, instance g occupies mem[{g, byte_addr}]
    logic [7:0]  mem [4096] = '{default: 8'h00};
    logic        rd_v [2][2];
    logic [10:0] rd_a [2][2];
    logic [7:0]  junk [2];

    // reference state
    logic [7:0]  ref_mem [2048];
    logic [10:0] hold_ad  [2];
    logic [7:0]  hold_din [2];
    logic [31:0] last_rd  [2];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_word_bridge #(.RD_LAT(g + 1)) dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid),
            .req_ready  (req_ready[g]),
            .req_we     (req_we),
            .req_addr   (req_addr),
            .req_wstrb  (req_wstrb),
            .req_wdata  (req_wdata),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .sram_ce    (sram_ce[g]),
            .sram_wre   (sram_wre[g]),
            .sram_ad    (sram_ad[g]),
            .sram_din   (sram_din[g]),
            .sram_dout  (sram_dout[g]),
            .dbg_state  (dbg_state[g])
        );
        assign sram_dout[g] = rd_v[g][g] ? mem[{1'(g), rd_a[g][g]}] : junk[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (sram_ce[g] && sram_wre[g]) mem[{1'(g), sram_ad[g]}] <= sram_din[g];
            rd_v[g][0] <= sram_ce[g] && !sram_wre[g];
            rd_a[g][0] <= sram_ad[g];
            rd_v[g][1] <= rd_v[g][0];
            rd_a[g][1] <= rd_a[g][0];
            junk[g]    <= 8'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [10:0] addr);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[{addr[10:2], 2'(k)}];
        return w;
    endfunction

    // Starts at the negedge of an idle cycle (cycle 0), ends at the negedge of the
    // first cycle in which both instances are idle again.
    task automatic do_txn(input logic we, input logic [10:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd);
        int n;
        int lanes [4];
        int t_end [2];
        int last;
        logic [31:0] exp_rd;
        logic e_ce, e_wre, e_rsp, e_rdy;
        n = 0;
        for (int k = 0; k < 4; k++) if (we && strb[k]) begin lanes[n] = k; n++; end
        exp_rd = ref_word(addr);
        for (int g = 0; g < 2; g++) t_end[g] = we ? n + 1 : 6 + g;
        last = (t_end[0] > t_end[1] ? t_end[0] : t_end[1]) + 1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wstrb = strb;
        req_wdata = wd;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_we    = 1'($urandom);
                req_addr  = 11'($urandom);
                req_wstrb = 4'($urandom);
                req_wdata = $urandom;
            end
            for (int g = 0; g < 2; g++) begin
                e_rdy = (c > t_end[g]);
                e_rsp = (c == t_end[g]);
                e_ce  = 1'b0;
                e_wre = 1'b0;
                if (we && c <= n) begin
                    e_ce = 1'b1;
                    e_wre = 1'b1;
                    hold_ad[g]  = {addr[10:2], 2'(lanes[c-1])};
                    hold_din[g] = wd[8*lanes[c-1] +: 8];
                end else if (!we && c <= 4) begin
                    e_ce = 1'b1;
                    hold_ad[g] = {addr[10:2], 2'(c - 1)};
                end
                check($sformatf("i%0d_c%0d_ctrl(rdy,rsp,ce,wre)", g, c),
                      {28'd0, req_ready[g], resp_valid[g], sram_ce[g], sram_wre[g]},
                      {28'd0, e_rdy, e_rsp, e_ce, e_wre});
                check($sformatf("i%0d_c%0d_ad", g, c), {21'd0, sram_ad[g]}, {21'd0, hold_ad[g]});
                check($sformatf("i%0d_c%0d_din", g, c), {24'd0, sram_din[g]}, {24'd0, hold_din[g]});
                if (e_rsp) begin
                    if (!we) last_rd[g] = exp_rd;
                    check($sformatf("i%0d_rdata", g), resp_rdata[g], last_rd[g]);
                end
            end
        end
        if (we) for (int k = 0; k < 4; k++) if (strb[k]) ref_mem[{addr[10:2], 2'(k)}] = wd[8*k +: 8];
    endtask

    // A read request held valid across busy periods: one acceptance per idle cycle.
    task automatic held_valid_reads(input logic [10:0] addr);
        int acc [2];
        int rsp [2];
        logic prev [2];
        logic [31:0] word_v;
        int w_len;
        int per;
        w_len = 22;
        word_v = ref_word(addr);
        for (int g = 0; g < 2; g++) begin acc[g] = 0; rsp[g] = 0; prev[g] = 1'b0; end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        req_wstrb = 4'($urandom);
        req_wdata = $urandom;
        for (int c = 0; c < 34; c++) begin
            if (c == w_len) req_valid = 1'b0;
            for (int g = 0; g < 2; g++) begin
                if (req_valid && req_ready[g]) acc[g]++;
                if (resp_valid[g]) begin
                    rsp[g]++;
                    check($sformatf("hv_i%0d_rdata", g), resp_rdata[g], word_v);
                    check($sformatf("hv_i%0d_single_pulse", g), {31'd0, prev[g]}, 32'd0);
                end
                prev[g] = resp_valid[g];
            end
            @(negedge clk);
        end
        for (int g = 0; g < 2; g++) begin
            per = 7 + g;
            check($sformatf("hv_i%0d_accepts", g), acc[g], (w_len + per - 1) / per);
            check($sformatf("hv_i%0d_resps", g), rsp[g], (w_len + per - 1) / per);
            check($sformatf("hv_i%0d_idle", g), {31'd0, req_ready[g]}, 32'd1);
            hold_ad[g] = {addr[10:2], 2'd3};
            last_rd[g] = word_v;
        end
    endtask

    // Reset lands in cycle 2 of a four-lane write.
    task automatic reset_mid_write(input logic [10:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wstrb = 4'hF;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_i%0d_c1_ce", g), {31'd0, sram_ce[g]}, 32'd1);
            check($sformatf("rst_i%0d_c1_ad", g), {21'd0, sram_ad[g]}, {21'd0, addr[10:2], 2'd0});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++)
            check($sformatf("rst_i%0d_c2_ctrl(rdy,rsp,ce)", g),
                  {29'd0, req_ready[g], resp_valid[g], sram_ce[g]}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_i%0d_c3_ctrl(rdy,rsp,ce,wre)", g),
                  {28'd0, req_ready[g], resp_valid[g], sram_ce[g], sram_wre[g]}, 32'd8);
            check($sformatf("rst_i%0d_c3_ad", g), {21'd0, sram_ad[g]}, 32'd0);
            check($sformatf("rst_i%0d_c3_din", g), {24'd0, sram_din[g]}, 32'd0);
            check($sformatf("rst_i%0d_c3_rdata", g), resp_rdata[g], 32'd0);
            hold_ad[g]  = '0;
            hold_din[g] = '0;
            last_rd[g]  = '0;
        end
        ref_mem[{addr[10:2], 2'd0}] = wd[7:0];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:0] word;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
        for (int g = 0; g < 2; g++) begin hold_ad[g] = '0; hold_din[g] = '0; last_rd[g] = '0; end

        // reset with a request presented, which must not be taken
        reset     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 11'h100;
        req_wstrb = 4'hF;
        req_wdata = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("init_i%0d_ctrl(rdy,rsp,ce,wre)", g),
                  {28'd0, req_ready[g], resp_valid[g], sram_ce[g], sram_wre[g]}, 32'd0);
            check($sformatf("init_i%0d_ad", g), {21'd0, sram_ad[g]}, 32'd0);
            check($sformatf("init_i%0d_din", g), {24'd0, sram_din[g]}, 32'd0);
            check($sformatf("init_i%0d_rdata", g), resp_rdata[g], 32'd0);
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++)
            check($sformatf("post_rst_i%0d_ctrl(rdy,ce)", g), {30'd0, req_ready[g], sram_ce[g]}, 32'd2);

        // directed cases
        do_txn(1'b1, 11'h010, 4'hF, 32'h11223344);
        do_txn(1'b0, 11'h010, 4'h0, 32'h0);
        for (int g = 0; g < 2; g++) check($sformatf("d1_i%0d_word", g), resp_rdata[g], 32'h11223344);
        do_txn(1'b1, 11'h7FC, 4'b0101, 32'hAABBCCDD);
        do_txn(1'b0, 11'h7FC, 4'h0, 32'h0);
        for (int g = 0; g < 2; g++) check($sformatf("d2_i%0d_word", g), resp_rdata[g], 32'h00BB00DD);
        do_txn(1'b1, 11'h020, 4'h0, 32'h55667788);
        do_txn(1'b0, 11'h013, 4'h0, 32'h0);
        for (int g = 0; g < 2; g++) check($sformatf("d3_i%0d_word", g), resp_rdata[g], 32'h11223344);
        do_txn(1'b0, 11'h020, 4'h0, 32'h0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            word = ($urandom_range(0, 9) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
            do_txn(1'($urandom), {word, 2'($urandom)}, 4'($urandom), $urandom);
        end

        reset_mid_write(11'h040, 32'hCAFEF00D);
        do_txn(1'b0, 11'h041, 4'h0, 32'h0);
        for (int g = 0; g < 2; g++) check($sformatf("rst_i%0d_word", g), resp_rdata[g], 32'h0000000D);

        held_valid_reads(11'h010);

        for (int t = 0; t < 10; t++) begin
            word = 9'($urandom_range(0, 15));
            do_txn(1'($urandom), {word, 2'($urandom)}, 4'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
